// File: rtl/sorter_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sorter_stream_ctrl
//
// Streaming front/back-end for a pipelined bitonic sorter.
//   * Input side: packs values from a valid/ready stream into a SIZE-slot
//     frame register that drives the sorter continuously. Short frames are
//     padded with a value that sorts to the tail (all-ones for ascending,
//     all-zeros for descending).
//   * Waits SORT_LATENCY cycles for the sorter, then captures the sorted
//     frame into an output buffer once that buffer is free.
//   * Output side: serialises the first out_count sorted values onto a
//     valid/ready stream; pad slots are never emitted.
//   Filling the next frame overlaps draining of the previous one.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous reset, active-high
//   s_valid   in   input value valid
//   s_ready   out  controller accepts an input value
//   s_data    in   input value
//   s_last    in   final value of the current frame
//   sort_in   out  frame to the sorter, slot i at [i*VALUE_BITS +: VALUE_BITS]
//   sort_out  in   sorted frame from the sorter, same packing
//   m_valid   out  output value valid
//   m_ready   in   downstream accepts
//   m_data    out  sorted output value
//   m_last    out  final valid value of the frame
// -----------------------------------------------------------------------------
module sorter_stream_ctrl #(
    parameter int VALUE_BITS   = 32,
    parameter int DEPTH        = 3,
    parameter bit DIRECTION    = 1'b0,
    parameter int SORT_LATENCY = DEPTH * (DEPTH + 1) / 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [VALUE_BITS-1:0]                s_data,
    input  logic                                 s_last,
    output logic [(1 << DEPTH)*VALUE_BITS-1:0]   sort_in,
    input  logic [(1 << DEPTH)*VALUE_BITS-1:0]   sort_out,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [VALUE_BITS-1:0]                m_data,
    output logic                                 m_last
);

    localparam int SIZE = 1 << DEPTH;
    localparam int TW   = $clog2(SORT_LATENCY + 1);
    localparam logic [VALUE_BITS-1:0] PAD = DIRECTION ? {VALUE_BITS{1'b0}} : {VALUE_BITS{1'b1}};

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_SORT = 1'b1
    } state_t;

    state_t                       r_state;
    logic                         r_s_ready;
    logic [DEPTH-1:0]             r_wr_idx;
    logic [DEPTH:0]               r_count;
    logic [TW-1:0]                r_timer;
    logic [SIZE*VALUE_BITS-1:0]   r_frame;
    logic [SIZE*VALUE_BITS-1:0]   r_buf;
    logic [DEPTH:0]               r_out_count;
    logic [DEPTH-1:0]             r_rd_idx;
    logic                         r_m_valid;
    logic [VALUE_BITS-1:0]        r_m_data;
    logic                         r_m_last;

    logic                         w_accept;
    logic                         w_frame_end;
    logic                         w_timer_done;
    logic                         w_buf_free;
    logic                         w_capture;
    logic                         w_out_hs;
    logic [DEPTH-1:0]             w_next_rd;

    // Handshake decode, sorter-latency expiry and output-buffer availability
    always_comb begin
        w_accept    = s_valid && s_ready && (r_state == ST_FILL);
        w_frame_end = w_accept && (s_last || (r_wr_idx == DEPTH'(SIZE - 1)));
        // The timer is loaded on the last-accept edge, so the capture edge is
        // the one on which it steps from 1 to 0 (or it has already reached 0).
        w_timer_done = (r_timer == TW'(0)) || (r_timer == TW'(1));
        w_out_hs     = r_m_valid && m_ready;
        // Buffer can be refilled on the same edge its final value leaves.
        w_buf_free   = !r_m_valid || (w_out_hs && r_m_last);
        w_capture    = (r_state == ST_SORT) && w_timer_done && w_buf_free;
        w_next_rd    = r_rd_idx + DEPTH'(1);
    end

    // Input FSM, frame register, sorter-latency timer and output serialiser
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_s_ready   <= 1'b1;
            r_wr_idx    <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_frame     <= '0;
            r_buf       <= '0;
            r_out_count <= '0;
            r_rd_idx    <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        // Write the accepted value; on the closing beat also
                        // pad every slot beyond it so stale data never sorts in.
                        for (int i = 0; i < SIZE; i++) begin
                            if (i == int'(r_wr_idx)) begin
                                r_frame[i*VALUE_BITS +: VALUE_BITS] <= s_data;
                            end else if (w_frame_end && (i > int'(r_wr_idx))) begin
                                r_frame[i*VALUE_BITS +: VALUE_BITS] <= PAD;
                            end
                        end
                        if (w_frame_end) begin
                            r_count   <= {1'b0, r_wr_idx} + (DEPTH+1)'(1);
                            r_timer   <= TW'(SORT_LATENCY);
                            r_wr_idx  <= '0;
                            r_state   <= ST_SORT;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_wr_idx  <= r_wr_idx + DEPTH'(1);
                        end
                    end
                end
                ST_SORT: begin
                    if (w_capture) begin
                        r_state   <= ST_FILL;
                        r_s_ready <= 1'b1;
                        r_timer   <= '0;
                    end else if (r_timer != TW'(0)) begin
                        r_timer   <= r_timer - TW'(1);
                    end
                end
                default: begin
                    r_state   <= ST_FILL;
                    r_s_ready <= 1'b1;
                end
            endcase

            // Capture takes priority: it only fires when the buffer is idle or
            // its final value is leaving on this very edge.
            if (w_capture) begin
                r_buf       <= sort_out;
                r_out_count <= r_count;
                r_rd_idx    <= '0;
                r_m_valid   <= 1'b1;
                r_m_data    <= sort_out[VALUE_BITS-1:0];
                r_m_last    <= (r_count == (DEPTH+1)'(1));
            end else if (w_out_hs) begin
                if (r_m_last) begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end else begin
                    r_rd_idx  <= w_next_rd;
                    r_m_data  <= r_buf[int'(w_next_rd)*VALUE_BITS +: VALUE_BITS];
                    r_m_last  <= ({1'b0, w_next_rd} == (r_out_count - (DEPTH+1)'(1)));
                end
            end
        end
    end

    // s_ready is forced low during reset so nothing is taken while it is held.
    assign s_ready = r_s_ready && !rst;
    assign sort_in = r_frame;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;

endmodule

// File: tb/tb_sorter_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sorter_stream_ctrl
//
// Two controllers (ascending and descending) share one input/output stimulus
// stream. Each is paired with a behavioural sorter (SORT_LATENCY-deep) and a
// scoreboard that turns every completed input frame into its sorted output
// sequence with queue sorting. Directed scenarios cover latency, short
// frames, backpressure, pad collisions and reset mid-drain; a randomized
// phase follows.
// -----------------------------------------------------------------------------
module tb_sorter_stream_ctrl;

    localparam int VB   = 8;
    localparam int DEP  = 3;
    localparam int SIZE = 8;
    localparam int LAT  = 6;
    localparam int FW   = SIZE * VB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [VB-1:0] s_data = '0;
    logic          m_ready = 1'b0;

    logic          s_ready_a, m_valid_a, m_last_a;
    logic [VB-1:0] m_data_a;
    logic [FW-1:0] sort_in_a, sort_out_a;
    logic          s_ready_b, m_valid_b, m_last_b;
    logic [VB-1:0] m_data_b;
    logic [FW-1:0] sort_in_b, sort_out_b;

    int unsigned   cyc = 0;
    int            n_checks = 0;
    int            n_fails = 0;
    int unsigned   hs_a = 0;
    int unsigned   hs_b = 0;

    logic [VB-1:0] cur[$];
    logic [VB-1:0] fa[$];
    logic [VB-1:0] fb[$];
    logic [VB:0]   exp_a[$];
    logic [VB:0]   exp_b[$];
    logic [VB:0]   ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sorter_stream_ctrl #(.VALUE_BITS(VB), .DEPTH(DEP), .DIRECTION(1'b0), .SORT_LATENCY(LAT)) u_dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .s_last(s_last), .sort_in(sort_in_a), .sort_out(sort_out_a), .m_valid(m_valid_a),
        .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a)
    );

    sorter_stream_ctrl #(.VALUE_BITS(VB), .DEPTH(DEP), .DIRECTION(1'b1), .SORT_LATENCY(LAT)) u_dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .s_last(s_last), .sort_in(sort_in_b), .sort_out(sort_out_b), .m_valid(m_valid_b),
        .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b)
    );

    // Behavioural sorter: full sort of a frame
    function automatic logic [FW-1:0] sort_frame(input logic [FW-1:0] f, input bit desc);
        logic [VB-1:0] v [SIZE];
        logic [VB-1:0] t;
        logic [FW-1:0] r;
        for (int i = 0; i < SIZE; i++) v[i] = f[i*VB +: VB];
        for (int i = 0; i < SIZE - 1; i++) begin
            for (int j = 0; j < SIZE - 1 - i; j++) begin
                if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < SIZE; i++) r[i*VB +: VB] = v[i];
        return r;
    endfunction

    // Sorter latency: sort_out reflects sort_in LAT edges after it settles
    logic [FW-1:0] pipe_a [LAT-1];
    logic [FW-1:0] pipe_b [LAT-1];
    always @(posedge clk) begin
        pipe_a[0] <= sort_in_a;
        pipe_b[0] <= sort_in_b;
        for (int i = 1; i < LAT - 1; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign sort_out_a = sort_frame(pipe_a[LAT-2], 1'b0);
    assign sort_out_b = sort_frame(pipe_b[LAT-2], 1'b1);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: observe handshakes just before the edge that completes them
    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (m_valid_a && m_ready) begin
                hs_a++;
                if (exp_a.size() == 0) begin
                    check_eq("a_extra_output", 64'(m_valid_a), 64'd0);
                end else begin
                    ea = exp_a.pop_front();
                    check_eq("a_data", 64'(m_data_a), 64'(ea[VB-1:0]));
                    check_eq("a_last", 64'(m_last_a), 64'(ea[VB]));
                end
            end
            if (m_valid_b && m_ready) begin
                hs_b++;
                if (exp_b.size() == 0) begin
                    check_eq("b_extra_output", 64'(m_valid_b), 64'd0);
                end else begin
                    eb = exp_b.pop_front();
                    check_eq("b_data", 64'(m_data_b), 64'(eb[VB-1:0]));
                    check_eq("b_last", 64'(m_last_b), 64'(eb[VB]));
                end
            end
            if (s_valid && s_ready_a) begin
                cur.push_back(s_data);
                if (s_last || cur.size() == SIZE) begin
                    fa = cur; fa.sort();
                    fb = cur; fb.rsort();
                    foreach (fa[i]) exp_a.push_back({(i == fa.size() - 1), fa[i]});
                    foreach (fb[i]) exp_b.push_back({(i == fb.size() - 1), fb[i]});
                    cur.delete();
                end
            end
        end
    end

    // Offer one value and hold it until accepted; returns just after that edge
    task automatic send(input logic [VB-1:0] d, input bit last);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        @(negedge clk);
        while (!s_ready_a && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) check_eq("send_timeout", 64'(s_ready_a), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        @(negedge clk);
        while (!m_valid_a && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check_eq(tag, 64'(m_valid_a), 64'd1);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        m_ready = 1'b1;
        @(negedge clk);
        while ((exp_a.size() != 0 || exp_b.size() != 0 || m_valid_a || m_valid_b) && t < 300) begin
            @(negedge clk); t++;
        end
        if (t >= 300) check_eq(tag, 64'(exp_a.size() + exp_b.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        logic [VB-1:0] v8 [SIZE];
        logic [VB-1:0] min_a;
        int unsigned   k, h0, hb0;
        int            r;

        // ---- Reset state ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", 64'(s_ready_a), 64'd0);
        check_eq("rst_m_valid", 64'(m_valid_a), 64'd0);
        check_eq("rst_m_last", 64'(m_last_a), 64'd0);
        check_eq("rst_m_data", 64'(m_data_a), 64'd0);
        check_eq("rst_sort_in", sort_in_a, 64'd0);
        check_eq("rst_m_valid_b", 64'(m_valid_b), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("s_ready_after_rst", 64'(s_ready_a), 64'd1);
        @(posedge clk); #1;

        // ---- Full frame, implicit last, latency and continuous output ----
        m_ready = 1'b1;
        v8 = '{8'd7, 8'd3, 8'd5, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        for (int i = 0; i < SIZE; i++) send(v8[i], 1'b0);
        k = cyc;
        @(negedge clk);
        check_eq("s_ready_low_after_last", 64'(s_ready_a), 64'd0);
        wait_valid("full_valid_timeout");
        check_eq("capture_latency", 64'(cyc - k), 64'(LAT));
        check_eq("s_ready_back_at_capture", 64'(s_ready_a), 64'd1);
        for (int j = 0; j < SIZE; j++) begin
            check_eq("full_stream_valid", 64'(m_valid_a), 64'd1);
            check_eq("full_last_pos", 64'(m_last_a), 64'(j == SIZE - 1));
            @(negedge clk);
        end
        check_eq("full_valid_drop", 64'(m_valid_a), 64'd0);
        @(posedge clk); #1;

        // ---- Short frame: pads written and never emitted ----
        h0 = hs_a;
        send(8'd9, 1'b0); send(8'd2, 1'b0); send(8'd5, 1'b1);
        @(negedge clk);
        check_eq("short_frame_slots", 64'(sort_in_a[23:0]), 64'h050209);
        check_eq("short_pad_asc", 64'(sort_in_a[63:24]), 64'hFF_FFFF_FFFF);
        check_eq("short_pad_desc", 64'(sort_in_b[63:24]), 64'd0);
        drain("short_drain_timeout");
        check_eq("short_hs_count", 64'(hs_a - h0), 64'd3);

        // ---- Backpressure: B waits in SORT until A's final handshake ----
        m_ready = 1'b0;
        min_a = 8'hFF;
        for (int i = 0; i < SIZE; i++) begin
            v8[i] = 8'($urandom_range(0, 255));
            if (v8[i] < min_a) min_a = v8[i];
            send(v8[i], 1'b0);
        end
        wait_valid("bp_a_valid_timeout");
        @(posedge clk); #1;
        for (int i = 0; i < SIZE; i++) send(8'($urandom_range(0, 255)), 1'b0);
        @(negedge clk);
        check_eq("bp_s_ready_drop", 64'(s_ready_a), 64'd0);
        repeat (20) @(negedge clk);
        check_eq("bp_hold_valid", 64'(m_valid_a), 64'd1);
        check_eq("bp_hold_s_ready", 64'(s_ready_a), 64'd0);
        check_eq("bp_hold_data", 64'(m_data_a), 64'(min_a));
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int j = 0; j < 2 * SIZE; j++) begin
            @(negedge clk);
            check_eq("bp_no_gap", 64'(m_valid_a), 64'd1);
        end
        @(negedge clk);
        check_eq("bp_done", 64'(m_valid_a), 64'd0);
        @(posedge clk); #1;

        // ---- PAD collision and descending order ----
        send(8'hFF, 1'b0); send(8'h00, 1'b0); send(8'hFF, 1'b1);
        drain("pad_drain_timeout");
        hb0 = hs_b;
        send(8'd4, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0); send(8'd7, 1'b0); send(8'd3, 1'b1);
        drain("desc_drain_timeout");
        check_eq("desc_hs_count", 64'(hs_b - hb0), 64'd5);

        // ---- Reset after 3 of 8 outputs ----
        m_ready = 1'b0;
        for (int i = 0; i < SIZE; i++) send(8'(8'd200 + 8'(i)), 1'b0);
        wait_valid("rst_drain_valid_timeout");
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_m_valid", 64'(m_valid_a), 64'd0);
        check_eq("mid_rst_s_ready", 64'(s_ready_a), 64'd1);
        check_eq("mid_rst_m_valid_b", 64'(m_valid_b), 64'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        h0 = hs_a;
        for (int i = 1; i <= SIZE; i++) send(8'(i), 1'b0);
        drain("post_rst_drain_timeout");
        check_eq("post_rst_hs_count", 64'(hs_a - h0), 64'd8);

        // ---- Randomized traffic with random backpressure ----
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            r = int'($urandom_range(0, 9));
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom_range(0, 255));
            s_last  = ($urandom_range(0, 4) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        send(8'h5A, 1'b1);
        drain("random_drain_timeout");
        check_eq("a_leftover", 64'(exp_a.size()), 64'd0);
        check_eq("b_leftover", 64'(exp_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
